// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: program counter, instruction-memory address
// and the IF/ID pipeline register, steered by the hazard unit's controls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        Flush,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_pc4,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid,
  output logic [4:0]  IFID_Register1,
  output logic [4:0]  IFID_Register2,
  output logic        misaligned
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic        r_misaligned;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_target_misaligned;

  assign w_pc_plus4          = r_pc + 32'd4;
  assign w_redirect_pc       = {jump_target[31:2], 2'b00};
  assign w_target_misaligned = |jump_target[1:0];

  // Flush overrides any stall so a resolved redirect is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else if (Flush) begin
      r_pc <= w_redirect_pc;
      if (w_target_misaligned) r_misaligned <= 1'b1;
    end else if (PCWrite && imem_ready) begin
      r_pc <= w_pc_plus4;
    end
  end

  // A held IF/ID (IFIDWrite=0) takes priority over the memory-wait bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_pc    <= RESET_PC;
      r_ifid_pc4   <= RESET_PC + 32'd4;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (Flush || (IFIDWrite && !imem_ready)) begin
      r_ifid_pc    <= r_pc;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (IFIDWrite) begin
      r_ifid_pc    <= r_pc;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_instr <= imem_rdata;
      r_ifid_valid <= 1'b1;
    end
  end

  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign IFID_pc        = r_ifid_pc;
  assign IFID_pc4       = r_ifid_pc4;
  assign IFID_instr     = r_ifid_instr;
  assign IFID_valid     = r_ifid_valid;
  assign IFID_Register1 = r_ifid_instr[19:15];
  assign IFID_Register2 = r_ifid_instr[24:20];
  assign misaligned     = r_misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns an address-tagged
// word so every fetched instruction identifies the PC it came from.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        Flush;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] IFID_pc;
  logic [31:0] IFID_pc4;
  logic [31:0] IFID_instr;
  logic        IFID_valid;
  logic [4:0]  IFID_Register1;
  logic [4:0]  IFID_Register2;
  logic        misaligned;

  int unsigned n_tests;
  int unsigned n_fail;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .Flush          (Flush),
    .jump_target    (jump_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .pc             (pc),
    .IFID_pc        (IFID_pc),
    .IFID_pc4       (IFID_pc4),
    .IFID_instr     (IFID_instr),
    .IFID_valid     (IFID_valid),
    .IFID_Register1 (IFID_Register1),
    .IFID_Register2 (IFID_Register2),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h00AB_C000;
  endfunction

  assign imem_rdata = tag(imem_addr);

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full IF/ID check: pc, IF/ID fields, valid and the rs1/rs2 slices.
  task automatic chk_ifid(input string name, input logic [31:0] e_pc,
                          input logic [31:0] e_ipc, input logic [31:0] e_instr,
                          input logic e_valid);
    logic [31:0] w;
    logic [31:0] e_pc4;
    w     = e_instr;
    e_pc4 = e_ipc + 32'd4;
    chk({name, ".pc"},       pc,         e_pc);
    chk({name, ".addr"},     imem_addr,  e_pc);
    chk({name, ".ifid_pc"},  IFID_pc,    e_ipc);
    chk({name, ".ifid_pc4"}, IFID_pc4,   e_pc4);
    chk({name, ".instr"},    IFID_instr, e_instr);
    chk({name, ".valid"},    {31'd0, IFID_valid}, {31'd0, e_valid});
    chk({name, ".rs1"},      {27'd0, IFID_Register1}, {27'd0, w[19:15]});
    chk({name, ".rs2"},      {27'd0, IFID_Register2}, {27'd0, w[24:20]});
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    Flush       = 1'b0;
    jump_target = '0;
    imem_ready  = 1'b1;

    step(); step();
    chk_ifid("reset", 32'h0, 32'h0, NOP, 1'b0);
    chk("reset.mis", {31'd0, misaligned}, 32'd0);

    // Sequential fetch
    rst_n = 1'b1;
    step(); chk_ifid("seq0", 32'h4, 32'h0, tag(32'h0), 1'b1);
    step(); chk_ifid("seq1", 32'h8, 32'h4, tag(32'h4), 1'b1);
    step(); chk_ifid("seq2", 32'hC, 32'h8, tag(32'h8), 1'b1);
    step(); chk_ifid("seq3", 32'h10, 32'hC, tag(32'hC), 1'b1);

    // Two-cycle stall at pc=0x10
    PCWrite = 1'b0; IFIDWrite = 1'b0;
    step(); chk_ifid("stall0", 32'h10, 32'hC, tag(32'hC), 1'b1);
    step(); chk_ifid("stall1", 32'h10, 32'hC, tag(32'hC), 1'b1);
    PCWrite = 1'b1; IFIDWrite = 1'b1;
    step(); chk_ifid("resume", 32'h14, 32'h10, tag(32'h10), 1'b1);
    step(); step(); step();
    chk_ifid("at20", 32'h20, 32'h1C, tag(32'h1C), 1'b1);

    // Redirect to 0x100
    Flush = 1'b1; jump_target = 32'h100;
    step(); chk_ifid("flush", 32'h100, 32'h20, NOP, 1'b0);
    Flush = 1'b0;
    step(); chk_ifid("target", 32'h104, 32'h100, tag(32'h100), 1'b1);

    // Flush together with full stall
    Flush = 1'b1; jump_target = 32'h40; PCWrite = 1'b0; IFIDWrite = 1'b0;
    step(); chk_ifid("flush_stall", 32'h40, 32'h104, NOP, 1'b0);
    Flush = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1;

    // Memory wait at pc=0x8: three bubbles then instr@0x8
    Flush = 1'b1; jump_target = 32'h8;
    step(); chk("to8.pc", pc, 32'h8);
    Flush = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_ifid("wait", 32'h8, 32'h8, NOP, 1'b0);
    end
    imem_ready = 1'b1;
    step(); chk_ifid("wait_done", 32'hC, 32'h8, tag(32'h8), 1'b1);

    // Memory wait while IF/ID is held: no bubble overwrites the held instr
    imem_ready = 1'b0; IFIDWrite = 1'b0;
    step(); chk_ifid("wait_hold", 32'hC, 32'h8, tag(32'h8), 1'b1);
    imem_ready = 1'b1; IFIDWrite = 1'b1;
    chk("mis.clear", {31'd0, misaligned}, 32'd0);

    // Misaligned redirect, then PC wrap
    Flush = 1'b1; jump_target = 32'h102;
    step(); chk("mis.pc", pc, 32'h100);
    chk("mis.set", {31'd0, misaligned}, 32'd1);
    jump_target = 32'hFFFF_FFFC;
    step(); chk("wrap.pre", pc, 32'hFFFF_FFFC);
    Flush = 1'b0;
    step(); chk_ifid("wrap", 32'h0, 32'hFFFF_FFFC, tag(32'hFFFF_FFFC), 1'b1);
    chk("mis.sticky", {31'd0, misaligned}, 32'd1);

    // Reset asserted mid-stall with a redirect pending
    step();
    PCWrite = 1'b0; IFIDWrite = 1'b0; Flush = 1'b1; jump_target = 32'h200;
    #2 rst_n = 1'b0;
    #1;
    chk_ifid("async_rst", 32'h0, 32'h0, NOP, 1'b0);
    chk("async_rst.mis", {31'd0, misaligned}, 32'd0);
    step(); chk("rst_hold.pc", pc, 32'h0);
    Flush = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1;
    rst_n = 1'b1;
    step(); chk_ifid("rst_resume", 32'h4, 32'h0, tag(32'h0), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register. It consumes the hazard unit's `PCWrite`, `IFIDWrite` and `Flush` controls and the ID-stage jump/branch target, and feeds `IFID_*` fields to decode and to the hazard unit's `IFID_Register1/2` inputs.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`) written on flush or bubble

- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `PCWrite`  in  1  1 = PC may advance; 0 = hold PC
- `IFIDWrite`  in  1  1 = IF/ID may load; 0 = hold IF/ID
- `Flush`  in  1  redirect: taken jump/branch resolved in ID
- `jump_target`  in  32  redirect PC, valid when `Flush`=1
- `imem_addr`  out  32  instruction-memory address (= `pc`), combinational
- `imem_rdata`  in  32  instruction word for `imem_addr`
- `imem_ready`  in  1  1 = `imem_rdata` valid this cycle
- `pc`  out  32  current fetch PC
- `IFID_pc`  out  32  PC of instruction in IF/ID
- `IFID_pc4`  out  32  `IFID_pc` + 4
- `IFID_instr`  out  32  instruction in IF/ID
- `IFID_valid`  out  1  1 = real instruction; 0 = bubble
- `IFID_Register1`  out  5  `IFID_instr[19:15]`
- `IFID_Register2`  out  5  `IFID_instr[24:20]`
- `misaligned`  out  1  sticky: a redirect target had `[1:0]` ≠ 0

## Operation
- PC update, priority order, on each rising edge:
  1. `Flush`=1: `pc` ← `{jump_target[31:2],2'b00}`. Applies even when `PCWrite`=0. If `jump_target[1:0]` ≠ 0, set `misaligned`.
  2. `PCWrite`=0: `pc` holds.
  3. `imem_ready`=0: `pc` holds (memory wait).
  4. Otherwise: `pc` ← `pc` + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- IF/ID update, priority order, on each rising edge:
  1. `Flush`=1: `IFID_instr` ← `NOP_INSTR`, `IFID_valid` ← 0, `IFID_pc`/`IFID_pc4` ← `pc`/`pc`+4. The wrong-path fetch is discarded.
  2. `IFIDWrite`=0: all IF/ID fields hold.
  3. `imem_ready`=0: insert bubble (`NOP_INSTR`, valid 0, pc fields ← `pc`).
  4. Otherwise: `IFID_instr` ← `imem_rdata`, `IFID_valid` ← 1, `IFID_pc` ← `pc`, `IFID_pc4` ← `pc`+4.
- `IFID_Register1/2` are wire slices of `IFID_instr`. A bubble therefore presents rs1=rs2=0, which never matches a non-zero rd in the hazard unit.
- `misaligned` clears only on reset.
- No FSM beyond the registers. The stage's "state" is {pc, IF/ID, misaligned}.

## Timing
- Reset (async assert, sync-safe release): `pc`=`RESET_PC`, `IFID_instr`=`NOP_INSTR`, `IFID_valid`=0, `IFID_pc`=`RESET_PC`, `IFID_pc4`=`RESET_PC`+4, `misaligned`=0.
- The first real instruction appears in IF/ID on the first edge after `rst_n` rises with `imem_ready`=1.
- Fetch latency: one cycle, from `imem_addr` presented to instruction in IF/ID.
- Redirect penalty: one bubble. The edge with `Flush`=1 loads PC=target and a NOP into IF/ID. The target instruction reaches IF/ID one edge later.
- Stall (`PCWrite`=`IFIDWrite`=0): PC and IF/ID are frozen for exactly the stalled cycles. `imem_addr` is stable throughout.
- Simultaneous `Flush` and stall: `Flush` wins for both PC and IF/ID.
- `imem_ready`=0 combined with `IFIDWrite`=0: IF/ID holds and no bubble overwrites the held instruction.
- Reset asserted mid-stall or mid-redirect: immediate return to reset values. No pending redirect survives.

## Test plan
- Reset then `imem_ready`=1, no hazards, imem returns `pc`-tagged words. Required: `pc` sequence 0, 4, 8, 12. IF/ID shows instr@0 with valid=1 one cycle after reset release.
- At `pc`=0x10, hold `PCWrite`=`IFIDWrite`=0 for 2 cycles. Required: `pc` stays 0x10 and `IFID_pc` stays 0x0C for 2 cycles, then the sequence resumes at 0x14.
- At `pc`=0x20, pulse `Flush`=1 with `jump_target`=0x100. Required: next cycle `pc`=0x100, `IFID_instr`=0x0000_0013, valid=0. One cycle later `IFID_pc`=0x100, valid=1.
- `Flush`=1 together with `PCWrite`=`IFIDWrite`=0, `jump_target`=0x40. Required: `pc`=0x40 and IF/ID=NOP; the redirect is not suppressed.
- Drop `imem_ready` for 3 cycles at `pc`=0x8. Required: `pc` holds 0x8 and IF/ID receives 3 bubbles (valid=0), then instr@0x8.
- `jump_target`=0x102. Required: `pc`=0x100 and `misaligned`=1, which stays set until `rst_n`=0. Also `pc`=0xFFFF_FFFC advancing normally. Required: wraps to 0x0.
